btn_debounce: RTL and testbench

BTN_DEBOUNCE -- requirements
Module: btn_debounce

---
 rtl/btn_debounce.sv | 188 ++++++++++++++++++
 tb/tb_btn_debounce.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//
// Debounces N_BTN asynchronous push-button inputs and presents a single
// priority-selected channel. The highest-index pressed channel wins. Each
// press produces a one-cycle pulse, and auto-repeat pulses can optionally
// follow while the button stays held.
//
// Parameters
//   N_BTN       : number of button channels (1..16)
//   DB_CYCLES   : consecutive differing cycles needed to flip a debounced bit
//   REPEAT_EN   : 1 enables auto-repeat pulses while a button is held
//   HOLD_CYCLES : cycles from a press pulse to the first repeat pulse
//   RPT_CYCLES  : cycles between subsequent repeat pulses
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   btn_i       : raw asynchronous active-high button levels
//   btn_level_o : debounced, priority-selected level (one-hot or zero)
//   btn_press_o : one-cycle press/repeat pulse on the selected channel
//   btn_any_o   : high when any channel's debounced state is pressed
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned DB_CYCLES   = 20000,
  parameter int unsigned REPEAT_EN   = 0,
  parameter int unsigned HOLD_CYCLES = 500000,
  parameter int unsigned RPT_CYCLES  = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] btn_press_o,
  output logic             btn_any_o
);

  localparam int unsigned DB_CNT_W = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_MAX  = (HOLD_CYCLES > RPT_CYCLES) ? HOLD_CYCLES : RPT_CYCLES;
  localparam int unsigned RC_W     = $clog2(RPT_MAX);

  localparam logic [DB_CNT_W-1:0] DB_LAST   = DB_CNT_W'(DB_CYCLES - 1);
  localparam logic [RC_W-1:0]     HOLD_LAST = RC_W'(HOLD_CYCLES - 1);
  localparam logic [RC_W-1:0]     RPT_LAST  = RC_W'(RPT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT
  } rpt_state_e;

  // Two-flop synchroniser
  logic [N_BTN-1:0] sync1_q;
  logic [N_BTN-1:0] sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Per-channel debounce: state flips once the synced input has disagreed
  // with it for DB_CYCLES consecutive cycles.
  logic [N_BTN-1:0]               db_state_q;
  logic [N_BTN-1:0][DB_CNT_W-1:0] db_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_state_q <= '0;
      db_cnt_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < N_BTN; i++) begin
        if (sync2_q[i] == db_state_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_state_q[i] <= ~db_state_q[i];
          db_cnt_q[i]   <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Priority select: ascending scan so the highest set index wins.
  logic [N_BTN-1:0] level;

  always_comb begin
    level = '0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (db_state_q[i]) begin
        level    = '0;
        level[i] = 1'b1;
      end
    end
  end

  // Previous selected level, used for edge detection and FSM restart.
  logic [N_BTN-1:0] level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level;
    end
  end

  logic level_changed;
  assign level_changed = (level != level_q);

  // Auto-repeat FSM
  rpt_state_e       state_q, state_d;
  logic [RC_W-1:0]  rcnt_q,  rcnt_d;
  logic             rpt_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q + 1'b1;
    rpt_fire = 1'b0;

    case (state_q)
      ST_IDLE: begin
        rcnt_d = '0;
      end
      ST_HOLD: begin
        if (rcnt_q == HOLD_LAST) begin
          rpt_fire = 1'b1;
          state_d  = ST_REPEAT;
          rcnt_d   = '0;
        end
      end
      ST_REPEAT: begin
        if (rcnt_q == RPT_LAST) begin
          rpt_fire = 1'b1;
          rcnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end
    endcase

    // A selection change restarts timing; the FSM state is stale this
    // cycle, so any repeat decision it would make is dropped.
    if (level_changed) begin
      state_d  = (|level) ? ST_HOLD : ST_IDLE;
      rcnt_d   = '0;
      rpt_fire = 1'b0;
    end

    if (REPEAT_EN == 0) begin
      state_d  = ST_IDLE;
      rcnt_d   = '0;
      rpt_fire = 1'b0;
    end
  end

  // level is one-hot or zero, so either term yields at most one set bit.
  always_comb begin
    btn_press_o = '0;
    if (level_changed) begin
      btn_press_o = level & ~level_q;
    end else if (rpt_fire) begin
      btn_press_o = level;
    end
  end

  assign btn_level_o = level;
  assign btn_any_o   = |db_state_q;

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn;

  logic [3:0] lvl0, prs0;
  logic       any0;
  logic [3:0] lvl1, prs1;
  logic       any1;

  int checks;
  int failures;

  btn_debounce #(
    .N_BTN(4), .DB_CYCLES(4), .REPEAT_EN(0), .HOLD_CYCLES(8), .RPT_CYCLES(4)
  ) u_norpt (
    .clk(clk), .rst_n(rst_n), .btn_i(btn),
    .btn_level_o(lvl0), .btn_press_o(prs0), .btn_any_o(any0)
  );

  btn_debounce #(
    .N_BTN(4), .DB_CYCLES(4), .REPEAT_EN(1), .HOLD_CYCLES(8), .RPT_CYCLES(4)
  ) u_rpt (
    .clk(clk), .rst_n(rst_n), .btn_i(btn),
    .btn_level_o(lvl1), .btn_press_o(prs1), .btn_any_o(any1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn = 4'b0000;
    repeat (14) tick();
  endtask

  task automatic test_reset();
    checks++;
    if ({lvl0, prs0, any0, lvl1, prs1, any1} !== 18'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=0", {lvl0, prs0, any0, lvl1, prs1, any1});
    end
  endtask

  task automatic test_single();
    logic [3:0] el, ep;
    btn = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      el = (k >= 6) ? 4'b0001 : 4'b0000;
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (lvl0 !== el || prs0 !== ep || any0 !== (k >= 6)) begin
        failures++;
        $display("FAIL single edge=%0d got lvl=%b prs=%b any=%b exp lvl=%b prs=%b any=%b",
                 k, lvl0, prs0, any0, el, ep, (k >= 6));
      end
    end
    settle();
    checks++;
    if (lvl0 !== 4'b0 || any0 !== 1'b0) begin
      failures++;
      $display("FAIL single_release got lvl=%b any=%b exp 0000/0", lvl0, any0);
    end
  endtask

  task automatic test_glitch();
    btn = 4'b0010;
    repeat (3) tick();
    btn = 4'b0000;
    for (int k = 4; k <= 14; k++) begin
      tick();
      checks++;
      if (lvl0 !== 4'b0 || prs0 !== 4'b0 || any0 !== 1'b0) begin
        failures++;
        $display("FAIL glitch edge=%0d got lvl=%b prs=%b any=%b exp 0", k, lvl0, prs0, any0);
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] el, ep;
    btn = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      tick();
      el = (k >= 6) ? 4'b0010 : 4'b0000;
      ep = (k == 6) ? 4'b0010 : 4'b0000;
      checks++;
      if (lvl0 !== el || prs0 !== ep) begin
        failures++;
        $display("FAIL prio_press edge=%0d got lvl=%b prs=%b exp lvl=%b prs=%b", k, lvl0, prs0, el, ep);
      end
    end
    btn = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      tick();
      el = (k >= 6) ? 4'b0001 : 4'b0010;
      ep = (k == 6) ? 4'b0001 : 4'b0000;
      checks++;
      if (lvl0 !== el || prs0 !== ep || any0 !== 1'b1) begin
        failures++;
        $display("FAIL prio_handover edge=%0d got lvl=%b prs=%b any=%b exp lvl=%b prs=%b any=1",
                 k, lvl0, prs0, any0, el, ep);
      end
    end
    settle();
  endtask

  task automatic test_repeat();
    logic [3:0] ep1, ep0;
    bit fell;
    btn = 4'b1000;
    for (int k = 1; k <= 30; k++) begin
      tick();
      ep1 = (k == 6 || k == 14 || k == 18 || k == 22 || k == 26 || k == 30) ? 4'b1000 : 4'b0000;
      ep0 = (k == 6) ? 4'b1000 : 4'b0000;
      checks++;
      if (prs1 !== ep1 || prs0 !== ep0) begin
        failures++;
        $display("FAIL repeat edge=%0d got rpt=%b norpt=%b exp rpt=%b norpt=%b", k, prs1, prs0, ep1, ep0);
      end
    end
    btn = 4'b0000;
    for (int k = 31; k <= 33; k++) begin
      tick();
      checks++;
      if (prs1 !== 4'b0) begin
        failures++;
        $display("FAIL repeat_release edge=%0d got=%b exp=0000", k, prs1);
      end
    end
    fell = 0;
    for (int k = 0; k < 20 && !fell; k++) begin
      tick();
      if (lvl1 === 4'b0) fell = 1;
    end
    checks++;
    if (!fell) begin
      failures++;
      $display("FAIL repeat_level_fall got lvl=%b exp=0000 within 20 cycles", lvl1);
    end
    for (int k = 0; k < 14; k++) begin
      checks++;
      if (prs1 !== 4'b0 || lvl1 !== 4'b0) begin
        failures++;
        $display("FAIL repeat_after_release step=%0d got prs=%b lvl=%b exp 0", k, prs1, lvl1);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] el, ep;
    btn = 4'b0100;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({lvl0, prs0, any0, lvl1, prs1, any1} !== 18'b0) begin
      failures++;
      $display("FAIL midreset_assert got=%b exp=0", {lvl0, prs0, any0, lvl1, prs1, any1});
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({lvl0, prs0, any0, lvl1, prs1, any1} !== 18'b0) begin
        failures++;
        $display("FAIL midreset_hold k=%0d got=%b exp=0", k, {lvl0, prs0, any0, lvl1, prs1, any1});
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      el = (k >= 6) ? 4'b0100 : 4'b0000;
      ep = (k == 6) ? 4'b0100 : 4'b0000;
      checks++;
      if (lvl0 !== el || prs0 !== ep || prs1 !== ep) begin
        failures++;
        $display("FAIL midreset_release edge=%0d got lvl=%b prs=%b rpt_prs=%b exp lvl=%b prs=%b",
                 k, lvl0, prs0, prs1, el, ep);
      end
    end
    settle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    btn      = 4'b0000;
    repeat (3) tick();
    test_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    test_single();
    test_glitch();
    test_priority();
    test_repeat();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
